// File: rtl/between_link_arbiter.sv
// rtl/between_link_arbiter.sv - round-robin arbiter sharing one 4-phase byte link among NUM_REQ sources
// Optional handshake watchdog enabled by defining BETWEEN_TIMEOUT_EN.
module between_link_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = 255,
  localparam int IDW           = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        done,
  output logic                      busy,
  output logic [IDW-1:0]            grant_id,
  output logic [DATA_W-1:0]         link_data,
  output logic                      tsent,
  input  logic                      trecieve,
  output logic                      timeout_err
);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_RELEASE, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [IDW-1:0]      rr_q, rr_d;
  logic [IDW-1:0]      grant_q, grant_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                tsent_q, tsent_d;
  logic [NUM_REQ-1:0]  done_q, done_d;
  logic                terr_q, terr_d;
  logic                any_req;
  logic [IDW-1:0]      win;
  logic [IDW-1:0]      idx;
  logic [IDW-1:0]      next_id;
  logic                timeout_hit;

  // Scan downward in offset so the lowest offset from the pointer wins.
  always_comb begin
    any_req = |req;
    win     = '0;
    idx     = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = IDW'((int'(rr_q) + k) % NUM_REQ);
      if (req[idx]) win = idx;
    end
  end

  assign next_id = (grant_q == IDW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;

`ifdef BETWEEN_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;

  // Reload on every entry to a waiting state, count down while waiting.
  always_comb begin
    cnt_d = cnt_q;
    if ((state_d != state_q) && (state_d == S_SEND || state_d == S_RELEASE))
      cnt_d = CW'(TIMEOUT_CYCLES);
    else if ((state_q == S_SEND || state_q == S_RELEASE) && cnt_q != '0)
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign timeout_hit = (cnt_q == '0);
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      rr_q    <= '0;
      grant_q <= '0;
      data_q  <= '0;
      tsent_q <= 1'b0;
      done_q  <= '0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      grant_q <= grant_d;
      data_q  <= data_d;
      tsent_q <= tsent_d;
      done_q  <= done_d;
      terr_q  <= terr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (any_req) state_d = S_SEND;
      S_SEND:    if (trecieve) state_d = S_RELEASE;
                 else if (timeout_hit) state_d = S_IDLE;
      S_RELEASE: if (!trecieve) state_d = S_DONE;
                 else if (timeout_hit) state_d = S_IDLE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rr_d    = rr_q;
    grant_d = grant_q;
    data_d  = data_q;
    tsent_d = tsent_q;
    done_d  = '0;
    terr_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (any_req) begin
          grant_d = win;
          data_d  = req_data[int'(win)*DATA_W +: DATA_W];
          tsent_d = 1'b1;
        end
      end
      S_SEND, S_RELEASE: begin
        if (state_q == S_SEND && trecieve) begin
          tsent_d = 1'b0;
        end else if (state_d == S_IDLE) begin
          // Aborted handshake: skip past this source so a dead far side cannot starve others.
          tsent_d = 1'b0;
          terr_d  = 1'b1;
          rr_d    = next_id;
          data_d  = '0;
        end
      end
      S_DONE: begin
        done_d[grant_q] = 1'b1;
        rr_d            = next_id;
        data_d          = '0;
      end
      default: ;
    endcase
  end

  always_comb begin
    busy        = (state_q != S_IDLE);
    done        = done_q;
    grant_id    = grant_q;
    link_data   = data_q;
    tsent       = tsent_q;
    timeout_err = terr_q;
  end

endmodule
